// File: rtl/add_arbiter_pkg.sv
// Shared types and constants for the add_arbiter block: FSM encoding, default
// sizes and the round-robin index helper.
package add_arbiter_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 64;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SEND = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_CALC = CALC,
    ST_SEND = SEND
  } state_e;

  // (base + off) folded back into 0..n-1; off never exceeds n.
  function automatic int wrap_idx(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/add_arbiter_if.sv
// Requester and result buses of add_arbiter. master = requesters/consumer,
// slave = the arbiter.
interface add_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 64
);
  // Handshake: a transfer happens on a rising clk edge where valid and ready are
  // both high; a source holds valid and its payload until that edge, and ready
  // may depend combinationally on valid.
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0]            req_ready;
  logic [N_REQ-1:0][WIDTH-1:0] req_a;
  logic [N_REQ-1:0][WIDTH-1:0] req_b;
  logic                        res_valid;
  logic                        res_ready;
  logic [WIDTH-1:0]            res_data;
  logic [$clog2(N_REQ)-1:0]    res_id;

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_data, res_id
  );

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_data, res_id
  );
endinterface

// File: rtl/add_arbiter_adder.sv
// Combinational WIDTH-bit adder; the carry-out is dropped (sum mod 2^WIDTH).
module add_arbiter_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out
);
  assign out = a + b;
endmodule

// File: rtl/add_arbiter.sv
// N_REQ-way arbiter in front of one shared adder: IDLE grants, CALC adds, SEND
// holds the result. `define ADD_ARBITER_FIXED_PRIO_EN for fixed priority.
module add_arbiter
  import add_arbiter_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic          clk,
  input  logic          rst,
  add_arbiter_if.slave  bus,
  output state_e        dbg_state
);
  localparam int IDW = $clog2(N_REQ);

  logic [1:0]       state;
  logic [IDW-1:0]   win_idx;
  logic             win_found;
  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [IDW-1:0]   op_id;
  logic [WIDTH-1:0] sum;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [IDW-1:0]   res_id_q;

`ifdef ADD_ARBITER_FIXED_PRIO_EN
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[IDW'(k)]) begin
        win_idx   = IDW'(k);
        win_found = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] ptr;

  // Scan from farthest to nearest so the first valid index after ptr wins.
  always_comb begin
    int j;
    j         = 0;
    win_idx   = '0;
    win_found = 1'b0;
    for (int k = N_REQ; k >= 1; k--) begin
      j = wrap_idx(int'(ptr), k, N_REQ);
      if (bus.req_valid[IDW'(j)]) begin
        win_idx   = IDW'(j);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= IDW'(N_REQ - 1);
    end else if (accept) begin
      ptr <= win_idx;
    end
  end
`endif

  assign accept        = (state == IDLE) && win_found && !rst;
  assign bus.req_ready = accept ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_idx) : '0;

  add_arbiter_adder #(.WIDTH(WIDTH)) u_adder (
    .a   (op_a),
    .b   (op_b),
    .out (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      op_a        <= '0;
      op_b        <= '0;
      op_id       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a  <= bus.req_a[win_idx];
            op_b  <= bus.req_b[win_idx];
            op_id <= win_idx;
            state <= CALC;
          end
        end
        CALC: begin
          res_data_q  <= sum;
          res_id_q    <= op_id;
          res_valid_q <= 1'b1;
          state       <= SEND;
        end
        SEND: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign dbg_state     = state_e'(state);

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: cycle-level reference model plus
// scenario tasks with explicit checks against known answers.
module tb_add_arbiter;
  import add_arbiter_pkg::*;

  localparam int N   = 4;
  localparam int W   = 64;
  localparam int IDW = 2;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  add_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();

  add_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [IDW+W-1:0] exp_q[$];
  logic [IDW+W-1:0] res_log[$];
  int               grant_log[$];
  int               mstate;
  int               mptr;
  int               last_grant;
  bit               auto_drop;
  int               cyc;
  int               grant_cyc;
  int               res_cyc;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_winner(input logic [N-1:0] v, input int p);
    int w;
    w = -1;
`ifdef ADD_ARBITER_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) if (w < 0 && v[i]) w = i;
    if (p < 0) w = -1;
`else
    for (int k = 1; k <= N; k++) if (w < 0 && v[(p + k) % N]) w = (p + k) % N;
`endif
    return w;
  endfunction

  task automatic model_reset();
    mstate = 0;
    mptr   = N - 1;
    exp_q.delete();
  endtask

  // Called at each falling edge: compares the DUT against the model and
  // advances the model to the state the DUT should take at the next rise.
  task automatic monitor();
    int               w;
    logic [N-1:0]     exp_rdy;
    logic [W-1:0]     s;
    last_grant = -1;
    w = model_winner(bus.req_valid, mptr);
    case (mstate)
      0: begin
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        n_cmp++;
        if (bus.req_ready !== exp_rdy || bus.res_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL idle_grant @%0d: req_ready=%b res_valid=%b, expected req_ready=%b res_valid=0",
                   cyc, bus.req_ready, bus.res_valid, exp_rdy);
        end
        if (w >= 0) begin
          s = bus.req_a[w] + bus.req_b[w];
          exp_q.push_back({IDW'(w), s});
          grant_log.push_back(w);
          grant_cyc  = cyc;
          last_grant = w;
          mptr       = w;
          mstate     = 1;
        end
      end
      1: begin
        n_cmp++;
        if (bus.req_ready !== '0 || bus.res_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL calc_state @%0d: req_ready=%b res_valid=%b, expected 0000 / 0",
                   cyc, bus.req_ready, bus.res_valid);
        end
        mstate = 2;
      end
      default: begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL send_orphan @%0d: result with empty expected queue", cyc);
        end else if (bus.res_valid !== 1'b1 || bus.req_ready !== '0 ||
                     {bus.res_id, bus.res_data} !== exp_q[0]) begin
          n_bad++;
          $display("FAIL send_result @%0d: valid=%b ready=%b id=%0d data=%h, expected valid=1 ready=0 id=%0d data=%h",
                   cyc, bus.res_valid, bus.req_ready, bus.res_id, bus.res_data,
                   exp_q[0][W +: IDW], exp_q[0][W-1:0]);
        end
        if (bus.res_ready) begin
          res_log.push_back({bus.res_id, bus.res_data});
          res_cyc = cyc;
          if (exp_q.size() > 0) void'(exp_q.pop_front());
          mstate = 0;
        end
      end
    endcase
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    cyc++;
    monitor();
    @(posedge clk);
    #1;
    if (auto_drop && last_grant >= 0) bus.req_valid[last_grant] = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.req_ready !== '0 || bus.res_valid !== 1'b0 || bus.res_data !== '0 ||
        bus.res_id !== '0 || dbg_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL reset_values: ready=%b valid=%b data=%h id=%0d state=%0d, expected 0/0/0/0/IDLE",
               bus.req_ready, bus.res_valid, bus.res_data, bus.res_id, dbg_state);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    grant_log.delete();
    res_log.delete();
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i]     = a;
    bus.req_b[i]     = b;
    bus.req_valid[i] = 1'b1;
  endtask

  task automatic wait_results(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (res_log.size() < n && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (res_log.size() < n) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d results, expected %0d", tag, res_log.size(), n);
    end
  endtask

  task automatic wait_grants(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (grant_log.size() < n && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (grant_log.size() < n) begin
      n_bad++;
      $display("FAIL %s_timeout: got %0d grants, expected %0d", tag, grant_log.size(), n);
    end
  endtask

  task automatic wait_state(input int st, input int budget, input string tag);
    int k;
    k = 0;
    while (mstate != st && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (mstate != st) begin
      n_bad++;
      $display("FAIL %s_timeout: model state %0d, expected %0d", tag, mstate, st);
    end
  endtask

  task automatic drain();
    int k;
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    k = 0;
    while (!(mstate == 0 && exp_q.size() == 0) && k < 20) begin
      step();
      k++;
    end
    n_cmp++;
    if (mstate != 0 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: state %0d, %0d results pending, expected 0/0", mstate, exp_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    bus.req_valid = '1;
    apply_reset();
    bus.req_valid = '0;
    step();
  endtask

  task automatic test_single();
    apply_reset();
    auto_drop     = 1'b1;
    bus.res_ready = 1'b1;
    set_req(0, 64'd5, 64'd7);
    wait_results(1, 10, "single");
    n_cmp++;
    if (res_log.size() < 1 || res_log[0] !== {2'd0, 64'd12}) begin
      n_bad++;
      $display("FAIL single_result: got %h, expected id=0 data=12", res_log.size() ? res_log[0] : '0);
    end
    n_cmp++;
    if (res_cyc - grant_cyc !== 2) begin
      n_bad++;
      $display("FAIL single_latency: %0d cycles, expected 2", res_cyc - grant_cyc);
    end
    drain();
  endtask

  task automatic test_contention();
    int exp_g[5] = '{0, 1, 2, 3, 0};
    apply_reset();
    auto_drop     = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, {$urandom, $urandom}, {$urandom, $urandom});
    wait_grants(5, 30, "contention");
    for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
      n_cmp++;
      if (grant_log[i] !== exp_g[i]) begin
        n_bad++;
        $display("FAIL contention_order[%0d]: granted %0d, expected %0d", i, grant_log[i], exp_g[i]);
      end
    end
    drain();
    for (int i = 0; i < res_log.size() && i < grant_log.size(); i++) begin
      n_cmp++;
      if (int'(res_log[i][W +: IDW]) !== grant_log[i]) begin
        n_bad++;
        $display("FAIL contention_id[%0d]: id %0d, expected %0d", i, res_log[i][W +: IDW], grant_log[i]);
      end
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    auto_drop     = 1'b1;
    bus.res_ready = 1'b1;
    set_req(1, '1, 64'd1);
    wait_results(1, 10, "wrap");
    n_cmp++;
    if (res_log.size() < 1 || res_log[0] !== {2'd1, 64'd0}) begin
      n_bad++;
      $display("FAIL wrap_result: got %h, expected id=1 data=0", res_log.size() ? res_log[0] : '0);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [IDW+W-1:0] held;
    apply_reset();
    auto_drop     = 1'b1;
    bus.res_ready = 1'b0;
    set_req(2, {$urandom, $urandom}, {$urandom, $urandom});
    wait_state(2, 10, "bp_send");
    held = {bus.res_id, bus.res_data};
    set_req(3, 64'd100, 64'd23);
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (bus.res_valid !== 1'b1 || bus.req_ready !== '0 || {bus.res_id, bus.res_data} !== held) begin
        n_bad++;
        $display("FAIL bp_hold[%0d]: valid=%b ready=%b id/data=%h, expected 1/0000/%h",
                 i, bus.res_valid, bus.req_ready, {bus.res_id, bus.res_data}, held);
      end
    end
    bus.res_ready = 1'b1;
    step();
    n_cmp++;
    if (dbg_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL bp_release: state %0d, expected IDLE", dbg_state);
    end
    wait_results(2, 10, "bp_next");
    n_cmp++;
    if (res_log.size() < 2 || res_log[1] !== {2'd3, 64'd123}) begin
      n_bad++;
      $display("FAIL bp_next_result: got %h, expected id=3 data=123", res_log.size() > 1 ? res_log[1] : '0);
    end
    drain();
  endtask

  task automatic test_two_requesters();
`ifdef ADD_ARBITER_FIXED_PRIO_EN
    int exp_g[4] = '{1, 1, 1, 1};
`else
    int exp_g[4] = '{1, 3, 1, 3};
`endif
    apply_reset();
    auto_drop     = 1'b0;
    bus.res_ready = 1'b1;
    set_req(1, 64'd10, 64'd1);
    set_req(3, 64'd30, 64'd3);
    wait_grants(4, 30, "two_req");
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      n_cmp++;
      if (grant_log[i] !== exp_g[i]) begin
        n_bad++;
        $display("FAIL two_req_order[%0d]: granted %0d, expected %0d", i, grant_log[i], exp_g[i]);
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    auto_drop     = 1'b1;
    bus.res_ready = 1'b1;
    set_req(2, 64'd40, 64'd2);
    wait_state(1, 10, "mid_calc");
    bus.req_valid = '1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== '0 || dbg_state !== ST_IDLE) begin
      n_bad++;
      $display("FAIL mid_calc_reset: valid=%b ready=%b state=%0d, expected 0/0000/IDLE",
               bus.res_valid, bus.req_ready, dbg_state);
    end
    model_reset();
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.res_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_calc_discard: res_valid=%b, expected 0", bus.res_valid);
    end
    rst = 1'b0;
    grant_log.delete();
    wait_grants(1, 5, "mid_regrant");
    n_cmp++;
    if (grant_log.size() < 1 || grant_log[0] !== 0) begin
      n_bad++;
      $display("FAIL mid_regrant: granted %0d, expected 0", grant_log.size() ? grant_log[0] : -1);
    end
    drain();
    set_req(1, 64'd8, 64'd9);
    wait_state(2, 10, "mid_send");
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.res_valid !== 1'b0 || bus.res_data !== '0 || bus.res_id !== '0) begin
      n_bad++;
      $display("FAIL mid_send_reset: valid=%b data=%h id=%0d, expected 0/0/0",
               bus.res_valid, bus.res_data, bus.res_id);
    end
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drain();
  endtask

  task automatic test_random();
    apply_reset();
    auto_drop = 1'b1;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 3) == 0)
          set_req(i, {$urandom, $urandom}, {$urandom, $urandom});
        else if (bus.req_valid[i] && $urandom_range(0, 7) == 0)
          bus.req_valid[i] = 1'b0;
      end
      bus.res_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst           = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b0;
    auto_drop     = 1'b0;
    cyc           = 0;
    grant_cyc     = 0;
    res_cyc       = 0;
    last_grant    = -1;
    model_reset();

    test_reset();
    test_single();
    test_contention();
    test_wrap();
    test_backpressure();
    test_two_requesters();
    test_reset_mid();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, legal range 2..16.
REQ-002 SHALL have parameter WIDTH, default 64: operand and result width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, N_REQ bits: per-requester operand-valid flags.
REQ-006 SHALL have port req_ready, output, N_REQ bits: per-requester accept, one-hot or zero.
REQ-007 SHALL have port req_a, input, N_REQ x WIDTH: per-requester operand A.
REQ-008 SHALL have port req_b, input, N_REQ x WIDTH: per-requester operand B.
REQ-009 SHALL have port res_valid, output, 1 bit: result available.
REQ-010 SHALL have port res_ready, input, 1 bit: consumer accepts the result.
REQ-011 SHALL have port res_data, output, WIDTH bits: the sum A+B.
REQ-012 SHALL have port res_id, output, $clog2(N_REQ) bits: index of the requester that owns res_data.

Function
REQ-013 SHALL implement FSM states IDLE, CALC and SEND.
REQ-014 SHALL, in IDLE, combinationally drive req_ready one-hot to the arbitration winner among asserted req_valid bits, and all-zero when no request is valid.
REQ-015 SHALL drive req_ready all-zero in CALC and SEND.
REQ-016 SHALL, on an IDLE handshake (req_valid[i] & req_ready[i]), register req_a[i], req_b[i] and i, update the grant pointer to i, and move to CALC.
REQ-017 SHALL, in CALC, register the output of the shared adder into res_data, set res_id, assert res_valid, and move to SEND.
REQ-018 SHALL, in SEND, hold res_valid, res_data and res_id stable until res_ready=1, then deassert res_valid and move to IDLE on the same edge.
REQ-019 SHALL give a latency from the accept edge to res_valid=1 of exactly 2 clk edges, and accept at most one request per 3 cycles.
REQ-020 SHALL compute the sum modulo 2^WIDTH, discarding the carry-out.
REQ-021 SHALL use round-robin arbitration: search from pointer+1 upward, wrapping from N_REQ-1 to 0; the first valid requester wins.
REQ-022 SHALL NOT grant a requester that deasserts req_valid before its handshake, and SHALL NOT update the pointer for it.
REQ-023 SHALL accept res_ready asserted in IDLE or CALC with no effect.

Reset
REQ-024 SHALL, while rst=1 and independent of clk, force state=IDLE, res_valid=0, res_data=0, res_id=0 and pointer=N_REQ-1, so that requester 0 has first priority.
REQ-025 SHALL discard any in-flight operation on reset, so that no result is delivered for it.
REQ-026 SHALL keep req_ready all-zero while rst=1.

Configuration
REQ-027 SHALL, with ADD_ARBITER_FIXED_PRIO_EN defined, use fixed priority (the lowest valid index wins) and neither use nor update the pointer.
REQ-028 SHALL, with ADD_ARBITER_FIXED_PRIO_EN undefined, use round-robin arbitration per REQ-021.

Structure
REQ-029 SHALL take the state enum type (IDLE, CALC, SEND) and the default constants for N_REQ and WIDTH from the shared package add_arbiter_pkg.
REQ-030 SHALL instantiate exactly one sub-module, the combinational adder (ports A, B, OUT), fed from the registered operands.

Verification
REQ-031 SHALL cover a single request: req0 valid with A=5, B=7; res_ready=1 -> res_valid high 2 edges after accept, res_data=12, res_id=0.
REQ-032 SHALL cover contention: all 4 requesters valid continuously -> grants in order 0,1,2,3,0; each result id matches its grant.
REQ-033 SHALL cover wrap-around: A=2^64-1, B=1 -> res_data=0.
REQ-034 SHALL cover backpressure: res_ready=0 for 5 cycles -> res_valid, res_data and res_id held stable, req_ready=0 throughout; res_ready=1 -> return to IDLE.
REQ-035 SHALL cover reset mid-operation: rst asserted in CALC -> res_valid=0 immediately without waiting for clk, no result delivered, and the next grant goes to requester 0.
REQ-036 SHALL cover the configuration: with ADD_ARBITER_FIXED_PRIO_EN defined and requesters 1 and 3 continuously valid -> requester 1 is always granted.
